mem_bus_ctrl: RTL
=================

Name: mem_bus_ctrl

Overview:
- Registered, handshaked successor to the combinational Memory_controller.
- Sits between the CPU data port ("Virt" side) and two targets: word-addressed synchronous RAM ("Phys") and the IO register block ("IO").
- Decodes each request once, holds target address, data and strobes for a parametrised number of wait states, and returns read data with a one-cycle ready pulse.
- Unmapped or misaligned accesses end with an error response and never strobe any target.

Parameters:
- DATA_W, 32, data width on every port.
- ADDR_W, 32, virtual address width.
- RAM_AW, 11, RAM word-address width (2^RAM_AW words).
- IO_AW, 4, IO word-address width.
- RAM_BASE, 32'h0000_0000, RAM region base, aligned to 2^(RAM_AW+2) bytes.
- IO_BASE, 32'hFFFF_0000, IO region base, aligned to 2^(IO_AW+2) bytes.
- RAM_WAIT, 1, extra access cycles for RAM (0..15).
- IO_WAIT, 2, extra access cycles for IO (0..15).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- reqVirt  in  1  access request; sampled only in IDLE.
- wEnVirt  in  1  1 = write, 0 = read; sampled with reqVirt.
- addressVirt  in  ADDR_W  byte address; sampled with reqVirt.
- dataInVirt  in  DATA_W  write data; sampled with reqVirt.
- dataOutVirt  out  DATA_W  read data (registered).
- readyVirt  out  1  one-cycle completion pulse.
- errVirt  out  1  valid with readyVirt; 1 = decode/alignment error.
- addressPhys  out  RAM_AW  RAM word address.
- dataInPhys  out  DATA_W  RAM write data.
- dataOutPhys  in  DATA_W  RAM read data.
- rEnPhys  out  1  RAM read strobe.
- wEnPhys  out  1  RAM write strobe.
- addressIO  out  IO_AW  IO word address.
- dataInIO  out  DATA_W  IO write data.
- dataOutIO  in  DATA_W  IO read data.
- rEnIO  out  1  IO read strobe.
- wEnIO  out  1  IO write strobe.

Behaviour:
- Reset: state IDLE, wait counter 0. All outputs 0: dataOutVirt, readyVirt, errVirt, every address, data and strobe output.
- Decode, combinational on the sampled request:
  - RAM hit when addressVirt[ADDR_W-1:RAM_AW+2] == RAM_BASE[ADDR_W-1:RAM_AW+2].
  - IO hit likewise with IO_AW and IO_BASE.
  - Word address is addressVirt[AW+1:2] for the hit region.
  - addressVirt[1:0] != 0 is misaligned, which is an error.
  - No hit is an error. RAM has priority if both regions hit (misconfiguration).
- FSM states: IDLE, RAM_ACC, IO_ACC, DONE.
- IDLE:
  - reqVirt=1 latches wEn, address and data, and loads the counter with RAM_WAIT or IO_WAIT.
  - Next state is RAM_ACC or IO_ACC; on error it is DONE with the error flag set.
  - reqVirt=0 keeps the block in IDLE.
- RAM_ACC / IO_ACC:
  - Selected target's address and data outputs are driven for all WAIT+1 cycles; the other target's outputs stay 0.
  - Read: rEn is high for all access cycles. On the edge ending the last cycle (counter==0), dataOut of the target is captured into dataOutVirt.
  - Write: wEn is high only in the last access cycle, giving exactly one write per request. dataOutVirt is unchanged.
  - The counter decrements each cycle; at 0 the next state is DONE.
- DONE:
  - readyVirt=1 and errVirt=flag for exactly one cycle; all strobes are 0; next state IDLE.
  - Error response: dataOutVirt is unchanged, and no target strobe is ever asserted.
- Latency, counting the request-sampling cycle as cycle 0:
  - Target access occupies cycles 1..WAIT+1; readyVirt is high in cycle WAIT+2.
  - Error: readyVirt and errVirt are high in cycle 1.
  - Back-to-back: reqVirt held high is next sampled in the IDLE cycle after DONE. Throughput is one request per WAIT+3 cycles.
- reqVirt and the other Virt inputs are ignored outside IDLE; the latched copies drive the targets.
- dataOutVirt holds the last successful read value until the next successful read.
- rst mid-access: on that edge all strobes drop to 0 and state goes to IDLE. If the final write cycle had not yet been reached, no write is issued. No readyVirt is produced for the aborted request.
- rst in the same cycle as reqVirt: reset wins and the request is dropped.

Decomposition:
- Package mem_bus_pkg:
  - FSM state enum (2-bit).
  - Default RAM_BASE/IO_BASE constants.
  - Region-select enum: NONE, RAM, IO.
- One sub-module, mem_bus_decode: purely combinational.
  - Inputs: address.
  - Outputs: region, word address, misaligned flag.
  - Parameterised by the base and width parameters.

Test Plan:
1. Read RAM: addressVirt=32'h0000_0004, dataOutPhys=32'hDEADBEEF, req cycle 0 → addressPhys=11'd1 with rEnPhys=1 in cycles 1-2; readyVirt=1, errVirt=0, dataOutVirt=32'hDEADBEEF in cycle 3.
2. Write IO: addressVirt=32'hFFFF_000C, dataInVirt=32'h12345678 → addressIO=4'd3, dataInIO=32'h12345678 in cycles 1-3, wEnIO=1 only in cycle 3, no RAM strobe ever, readyVirt in cycle 4, dataOutVirt unchanged.
3. Unmapped read at 32'h1000_0008, then misaligned write at 32'h0000_0006 → each gives readyVirt=errVirt=1 one cycle after request; all target strobes stay 0 throughout.
4. reqVirt held high for two RAM reads (addresses 0 then 4) → ready pulses exactly 4 cycles apart; the second address is sampled in the IDLE cycle after DONE.
5. rst asserted in cycle 2 of an IO write → wEnIO never asserted; all outputs 0 the cycle after reset; no readyVirt; a following read completes normally.
6. IO read with dataOutIO=32'hFEFEFEFE, then a write → dataOutVirt stays 32'hFEFEFEFE after the write completes.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// ============================================================================
// Module      : mem_bus_pkg
// Description : Shared types and default region bases for the memory bus
//               controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RAM_ACC = 2'd1,
    ST_IO_ACC  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_RAM  = 2'd1,
    REG_IO   = 2'd2
  } region_t;

  localparam logic [31:0] c_RAM_BASE_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] c_IO_BASE_DEFAULT  = 32'hFFFF_0000;

endpackage

`default_nettype wire

// File: rtl/mem_bus_decode.sv
// ============================================================================
// Module      : mem_bus_decode
// Description : Combinational address decode into RAM / IO region, word
//               address and misalignment flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_decode
  import mem_bus_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              RAM_AW   = 11,
  parameter int              IO_AW    = 4,
  parameter logic [ADDR_W-1:0] RAM_BASE = ADDR_W'(c_RAM_BASE_DEFAULT),
  parameter logic [ADDR_W-1:0] IO_BASE  = ADDR_W'(c_IO_BASE_DEFAULT)
) (
  input  logic [ADDR_W-1:0] address,
  output region_t           region,
  output logic [RAM_AW-1:0] ramWordAddr,
  output logic [IO_AW-1:0]  ioWordAddr,
  output logic              misaligned
);

  logic w_ramHit;
  logic w_ioHit;

  assign w_ramHit = (address[ADDR_W-1:RAM_AW+2] == RAM_BASE[ADDR_W-1:RAM_AW+2]);
  assign w_ioHit  = (address[ADDR_W-1:IO_AW+2]  == IO_BASE[ADDR_W-1:IO_AW+2]);

  // RAM wins when both regions overlap, which only happens on misconfiguration
  always_comb begin
    region = REG_NONE;
    if (w_ramHit) begin
      region = REG_RAM;
    end else if (w_ioHit) begin
      region = REG_IO;
    end
  end

  assign ramWordAddr = address[RAM_AW+1:2];
  assign ioWordAddr  = address[IO_AW+1:2];
  assign misaligned  = |address[1:0];

endmodule

`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
// ============================================================================
// Module      : mem_bus_ctrl
// Description : Registered, handshaked bridge from the CPU data port to RAM
//               and IO targets with per-target wait states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                RAM_AW   = 11,
  parameter int                IO_AW    = 4,
  parameter logic [ADDR_W-1:0] RAM_BASE = ADDR_W'(c_RAM_BASE_DEFAULT),
  parameter logic [ADDR_W-1:0] IO_BASE  = ADDR_W'(c_IO_BASE_DEFAULT),
  parameter int                RAM_WAIT = 1,
  parameter int                IO_WAIT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqVirt,
  input  logic              wEnVirt,
  input  logic [ADDR_W-1:0] addressVirt,
  input  logic [DATA_W-1:0] dataInVirt,
  output logic [DATA_W-1:0] dataOutVirt,
  output logic              readyVirt,
  output logic              errVirt,
  output logic [RAM_AW-1:0] addressPhys,
  output logic [DATA_W-1:0] dataInPhys,
  input  logic [DATA_W-1:0] dataOutPhys,
  output logic              rEnPhys,
  output logic              wEnPhys,
  output logic [IO_AW-1:0]  addressIO,
  output logic [DATA_W-1:0] dataInIO,
  input  logic [DATA_W-1:0] dataOutIO,
  output logic              rEnIO,
  output logic              wEnIO
);

  localparam logic [3:0] c_RAM_WAIT = 4'(RAM_WAIT);
  localparam logic [3:0] c_IO_WAIT  = 4'(IO_WAIT);

  state_t            r_state;
  state_t            w_nextState;
  logic [3:0]        r_cnt;
  logic              r_wEn;
  logic              r_err;
  logic [RAM_AW-1:0] r_ramAddr;
  logic [IO_AW-1:0]  r_ioAddr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_dataOut;

  region_t           w_region;
  logic [RAM_AW-1:0] w_ramWord;
  logic [IO_AW-1:0]  w_ioWord;
  logic              w_misaligned;
  logic              w_decErr;
  logic              w_lastCycle;
  logic              w_inRam;
  logic              w_inIo;

  mem_bus_decode #(
    .ADDR_W   (ADDR_W),
    .RAM_AW   (RAM_AW),
    .IO_AW    (IO_AW),
    .RAM_BASE (RAM_BASE),
    .IO_BASE  (IO_BASE)
  ) u_decode (
    .address     (addressVirt),
    .region      (w_region),
    .ramWordAddr (w_ramWord),
    .ioWordAddr  (w_ioWord),
    .misaligned  (w_misaligned)
  );

  assign w_decErr    = w_misaligned || (w_region == REG_NONE);
  assign w_lastCycle = (r_cnt == 4'd0);
  assign w_inRam     = (r_state == ST_RAM_ACC);
  assign w_inIo      = (r_state == ST_IO_ACC);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_wEn     <= 1'b0;
      r_err     <= 1'b0;
      r_ramAddr <= '0;
      r_ioAddr  <= '0;
      r_data    <= '0;
      r_dataOut <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        ST_IDLE: begin
          if (reqVirt) begin
            r_wEn     <= wEnVirt;
            r_err     <= w_decErr;
            r_ramAddr <= w_ramWord;
            r_ioAddr  <= w_ioWord;
            r_data    <= dataInVirt;
            r_cnt     <= (w_region == REG_IO) ? c_IO_WAIT : c_RAM_WAIT;
          end
        end
        ST_RAM_ACC, ST_IO_ACC: begin
          // Read data is taken on the edge that closes the final access cycle
          if (!w_lastCycle) begin
            r_cnt <= r_cnt - 4'd1;
          end else if (!r_wEn) begin
            r_dataOut <= w_inRam ? dataOutPhys : dataOutIO;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (reqVirt) begin
          if (w_decErr) begin
            w_nextState = ST_DONE;
          end else if (w_region == REG_IO) begin
            w_nextState = ST_IO_ACC;
          end else begin
            w_nextState = ST_RAM_ACC;
          end
        end
      end
      ST_RAM_ACC, ST_IO_ACC: begin
        if (w_lastCycle) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Target buses are gated by state so the idle target always sees zeros
  assign addressPhys = w_inRam ? r_ramAddr : '0;
  assign dataInPhys  = w_inRam ? r_data : '0;
  assign rEnPhys     = w_inRam && !r_wEn;
  assign wEnPhys     = w_inRam && r_wEn && w_lastCycle;

  assign addressIO   = w_inIo ? r_ioAddr : '0;
  assign dataInIO    = w_inIo ? r_data : '0;
  assign rEnIO       = w_inIo && !r_wEn;
  assign wEnIO       = w_inIo && r_wEn && w_lastCycle;

  assign dataOutVirt = r_dataOut;
  assign readyVirt   = (r_state == ST_DONE);
  assign errVirt     = (r_state == ST_DONE) && r_err;

endmodule

`default_nettype wire
